regfile_cmd_sequencer: RTL and testbench

REGFILE_CMD_SEQUENCER -- requirements
Module: regfile_cmd_sequencer

---
 rtl/regfile_cmd_sequencer.sv | 153 +++++++++++++++
 tb/tb_regfile_cmd_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_cmd_sequencer.sv
// Command FIFO feeding a register-file control sequencer. LOAD/MOVE/NOP take one cycle;
// SWAP expands into three register-file moves through a scratch register.
module regfile_cmd_sequencer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TEMP_REG = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_src,
  input  logic [2:0]  cmd_dst,
  input  logic [15:0] cmd_data,
  output logic [2:0]  source,
  output logic [2:0]  destination,
  output logic        move,
  output logic        in,
  output logic [15:0] data_in,
  output logic        busy,
  output logic [4:0]  fifo_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DepthCnt = 5'(DEPTH);
  localparam logic [2:0] TempReg  = 3'(TEMP_REG);

  localparam logic [1:0] OpNop  = 2'b00;
  localparam logic [1:0] OpLoad = 2'b01;
  localparam logic [1:0] OpMove = 2'b10;
  localparam logic [1:0] OpSwap = 2'b11;

  typedef enum logic [1:0] {StIdle, StSwapA, StSwapB} state_e;

  state_e          state_q, state_d;
  logic [23:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [4:0]      count_q, count_d;
  logic [2:0]      swap_src_q, swap_src_d, swap_dst_q, swap_dst_d;
  logic [2:0]      source_q, source_d, destination_q, destination_d;
  logic [15:0]     data_q, data_d;
  logic            move_q, move_d, in_q, in_d;
  logic            push, pop;

  logic [1:0]      head_op;
  logic [2:0]      head_src, head_dst;
  logic [15:0]     head_data;

  assign {head_op, head_src, head_dst, head_data} = mem_q[rd_ptr_q];

  // Ready ignores a same-cycle pop: a full FIFO never accepts.
  assign cmd_ready = rst_n && (count_q < DepthCnt);
  assign push      = cmd_valid && cmd_ready;

  always_comb begin
    state_d       = state_q;
    swap_src_d    = swap_src_q;
    swap_dst_d    = swap_dst_q;
    source_d      = source_q;
    destination_d = destination_q;
    data_d        = data_q;
    move_d        = 1'b0;
    in_d          = 1'b0;
    pop           = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != 5'd0) begin
          pop = 1'b1;
          case (head_op)
            OpLoad: begin
              in_d          = 1'b1;
              destination_d = head_dst;
              data_d        = head_data;
            end
            OpMove: begin
              move_d        = 1'b1;
              source_d      = head_src;
              destination_d = head_dst;
            end
            OpSwap: begin
              // A self-swap is a no-op; everything else goes through the scratch register.
              if (head_src != head_dst) begin
                move_d        = 1'b1;
                source_d      = head_src;
                destination_d = TempReg;
                swap_src_d    = head_src;
                swap_dst_d    = head_dst;
                state_d       = StSwapA;
              end
            end
            OpNop: ;
            default: ;
          endcase
        end
      end
      StSwapA: begin
        move_d        = 1'b1;
        source_d      = swap_dst_q;
        destination_d = swap_src_q;
        state_d       = StSwapB;
      end
      StSwapB: begin
        move_d        = 1'b1;
        source_d      = TempReg;
        destination_d = swap_dst_q;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
    count_d = count_q + {4'b0, push} - {4'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      swap_src_q    <= '0;
      swap_dst_q    <= '0;
      source_q      <= '0;
      destination_q <= '0;
      data_q        <= '0;
      move_q        <= 1'b0;
      in_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      swap_src_q    <= swap_src_d;
      swap_dst_q    <= swap_dst_d;
      source_q      <= source_d;
      destination_q <= destination_d;
      data_q        <= data_d;
      move_q        <= move_d;
      in_q          <= in_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_src, cmd_dst, cmd_data};
  end

  assign source      = source_q;
  assign destination = destination_q;
  assign move        = move_q;
  assign in          = in_q;
  assign data_in     = data_q;
  assign fifo_count  = count_q;
  assign busy        = (count_q != 5'd0) || (state_q != StIdle);

endmodule

// File: tb/tb_regfile_cmd_sequencer.sv
// Bench for regfile_cmd_sequencer: directed scenarios plus random traffic, compared each cycle
// against a queue-based model that expands commands into per-cycle register-file actions.
module tb_regfile_cmd_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TEMP  = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_src, cmd_dst;
  logic [15:0] cmd_data;
  logic [2:0]  source, destination;
  logic        move, in, busy;
  logic [15:0] data_in;
  logic [4:0]  fifo_count;

  int checks   = 0;
  int failures = 0;
  int stepno   = 0;

  typedef struct packed {
    logic [1:0]  op;
    logic [2:0]  s;
    logic [2:0]  d;
    logic [15:0] data;
  } cmd_t;

  // kind: 0 = no strobe, 1 = move, 2 = load
  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  s;
    logic [2:0]  d;
    logic [15:0] data;
  } act_t;

  cmd_t mq[$];
  act_t pq[$];
  logic [2:0]  e_src, e_dst;
  logic [15:0] e_data;
  logic        e_move, e_in;

  regfile_cmd_sequencer #(.DEPTH(DEPTH), .TEMP_REG(TEMP)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_data(cmd_data),
    .source(source), .destination(destination), .move(move), .in(in),
    .data_in(data_in), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s@%0d: observed=%0h expected=%0h", tag, stepno, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] op, input logic [2:0] s,
                      input logic [2:0] d, input logic [15:0] dat, input logic r);
    act_t a;
    cmd_t c;
    logic acc, have;
    @(negedge clk);
    rst_n = r; cmd_valid = v; cmd_op = op; cmd_src = s; cmd_dst = d; cmd_data = dat;
    #1;
    acc = r && (mq.size() < DEPTH);
    chk("cmd_ready", 32'(cmd_ready), 32'(acc));
    acc = acc && v;
    @(posedge clk);
    stepno++;
    if (!r) begin
      mq.delete(); pq.delete();
      e_src = '0; e_dst = '0; e_data = '0; e_move = 1'b0; e_in = 1'b0;
    end else begin
      e_move = 1'b0; e_in = 1'b0; have = 1'b0;
      a = '0;
      if (pq.size() > 0) begin
        a = pq.pop_front(); have = 1'b1;
      end else if (mq.size() > 0) begin
        c = mq.pop_front(); have = 1'b1;
        case (c.op)
          2'b01: a = '{kind: 2'd2, s: c.s, d: c.d, data: c.data};
          2'b10: a = '{kind: 2'd1, s: c.s, d: c.d, data: 16'h0};
          2'b11: if (c.s != c.d) begin
            a = '{kind: 2'd1, s: c.s, d: 3'(TEMP), data: 16'h0};
            pq.push_back('{kind: 2'd1, s: c.d, d: c.s, data: 16'h0});
            pq.push_back('{kind: 2'd1, s: 3'(TEMP), d: c.d, data: 16'h0});
          end
          default: ;
        endcase
      end
      if (have && a.kind == 2'd1) begin
        e_move = 1'b1; e_src = a.s; e_dst = a.d;
      end else if (have && a.kind == 2'd2) begin
        e_in = 1'b1; e_dst = a.d; e_data = a.data;
      end
      if (acc) mq.push_back('{op: op, s: s, d: d, data: dat});
    end
    #1;
    chk("move", 32'(move), 32'(e_move));
    chk("in", 32'(in), 32'(e_in));
    chk("source", 32'(source), 32'(e_src));
    chk("destination", 32'(destination), 32'(e_dst));
    chk("data_in", 32'(data_in), 32'(e_data));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("busy", 32'(busy), 32'((mq.size() != 0) || (pq.size() != 0)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 3'd0, 3'd0, 16'h0, 1'b1);
  endtask

  // Hold the command with valid high until the model says it is taken.
  task automatic push_cmd(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d,
                          input logic [15:0] dat);
    logic taken;
    for (int i = 0; i < 20; i++) begin
      taken = (mq.size() < DEPTH);
      step(1'b1, op, s, d, dat, 1'b1);
      if (taken) return;
    end
    checks++;
    failures++;
    $error("FAIL accept_timeout@%0d: observed=not_accepted expected=accepted", stepno);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_src = '0; cmd_dst = '0; cmd_data = '0;
    e_src = '0; e_dst = '0; e_data = '0; e_move = 1'b0; e_in = 1'b0;

    // Reset, with a command offered that must be ignored.
    step(1'b0, 2'b00, 3'd0, 3'd0, 16'h0, 1'b0);
    step(1'b1, 2'b01, 3'd2, 3'd5, 16'hBEEF, 1'b0);
    idle(2);

    // Single LOAD.
    push_cmd(2'b01, 3'd0, 3'd3, 16'd15);
    idle(3);

    // LOAD then MOVE back to back.
    push_cmd(2'b01, 3'd0, 3'd1, 16'd15);
    push_cmd(2'b10, 3'd1, 3'd3, 16'h0);
    idle(3);

    // SWAP followed by a queued MOVE.
    push_cmd(2'b11, 3'd1, 3'd3, 16'h0);
    push_cmd(2'b10, 3'd4, 3'd5, 16'h0);
    idle(6);

    // Stalled SWAP heads fill the FIFO while valid stays high.
    push_cmd(2'b11, 3'd1, 3'd2, 16'h0);
    push_cmd(2'b11, 3'd3, 3'd4, 16'h0);
    push_cmd(2'b11, 3'd5, 3'd6, 16'h0);
    push_cmd(2'b01, 3'd0, 3'd2, 16'h1234);
    push_cmd(2'b10, 3'd2, 3'd0, 16'h0);
    push_cmd(2'b01, 3'd0, 3'd6, 16'hA5A5);
    push_cmd(2'b10, 3'd6, 3'd1, 16'h0);
    idle(10);

    // Reset during a SWAP with entries queued behind it.
    push_cmd(2'b11, 3'd1, 3'd2, 16'h0);
    push_cmd(2'b11, 3'd3, 3'd4, 16'h0);
    push_cmd(2'b01, 3'd0, 3'd5, 16'h0055);
    push_cmd(2'b10, 3'd5, 3'd6, 16'h0);
    push_cmd(2'b01, 3'd0, 3'd1, 16'h0011);
    step(1'b0, 2'b00, 3'd0, 3'd0, 16'h0, 1'b0);
    idle(4);

    // Self-swap and NOP produce no strobes.
    push_cmd(2'b11, 3'd2, 3'd2, 16'h0);
    push_cmd(2'b00, 3'd0, 3'd0, 16'h0);
    idle(3);

    // Random traffic, including swaps through the scratch register and occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 79) != 0));
    end
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
